// File: rtl/pa_core_xreg_mp_if.sv
// Register-file bus: read ports, write-back ports and scoreboard issue/status signals.
// The master drives addresses, writes and scoreboard sets; the slave is the register file.
interface pa_core_xreg_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic [RD_PORTS*AW-1:0]         rd_addr_i;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_o;
  logic [RD_PORTS-1:0]            rd_busy_o;
  logic [WR_PORTS*AW-1:0]         wr_addr_i;
  logic [WR_PORTS-1:0]            wr_vld_i;
  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data_i;
  logic [AW-1:0]                  sb_set_addr_i;
  logic                           sb_set_vld_i;
  logic                           sb_conflict_o;
  logic [AW:0]                    pend_cnt_o;

  modport master (
    output rd_addr_i, wr_addr_i, wr_vld_i, wr_data_i, sb_set_addr_i, sb_set_vld_i,
    input  rd_data_o, rd_busy_o, sb_conflict_o, pend_cnt_o
  );

  modport slave (
    input  rd_addr_i, wr_addr_i, wr_vld_i, wr_data_i, sb_set_addr_i, sb_set_vld_i,
    output rd_data_o, rd_busy_o, sb_conflict_o, pend_cnt_o
  );
endinterface

// File: rtl/pa_core_xreg_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Read ports report busy for RAW stalls; optional same-cycle write-to-read bypass.
module pa_core_xreg_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int BYPASS     = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pa_core_xreg_mp_if.slave   bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] regs   [REG_NUM];
  logic [DATA_WIDTH-1:0] wr_win [REG_NUM];
  logic [REG_NUM-1:0]    wr_hit;
  logic [REG_NUM-1:0]    sb_hit;
  logic [REG_NUM-1:0]    pend;
  logic [REG_NUM-1:0]    pend_nxt;
  logic [CW-1:0]         pend_cnt;
  logic [CW-1:0]         cnt_nxt;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < REG_NUM; r++) wr_win[r] = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (bus.wr_vld_i[p] && (bus.wr_addr_i[p*AW +: AW] != '0)) begin
        wr_hit[bus.wr_addr_i[p*AW +: AW]] = 1'b1;
        wr_win[bus.wr_addr_i[p*AW +: AW]] = bus.wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    sb_hit = '0;
    if (bus.sb_set_vld_i && (bus.sb_set_addr_i != '0)) sb_hit[bus.sb_set_addr_i] = 1'b1;
  end

  // A new producer's set outranks a same-cycle clear from an older result.
  assign pend_nxt = sb_hit | (pend & ~wr_hit);

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < REG_NUM; r++) cnt_nxt = cnt_nxt + CW'(pend_nxt[r]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (wr_hit[r]) regs[r] <= wr_win[r];
      end
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Register 0 is never written and never pending, so plain indexing already reads it as zero.
  always_comb begin
    logic [AW-1:0] ra;
    logic          byp;
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      ra  = bus.rd_addr_i[k*AW +: AW];
      byp = (BYPASS != 0) && wr_hit[ra];
      bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = byp ? wr_win[ra] : regs[ra];
      bus.rd_busy_o[k] = pend[ra] && !byp;
    end
  end

  assign bus.sb_conflict_o = bus.sb_set_vld_i && (bus.sb_set_addr_i != '0) &&
                             pend[bus.sb_set_addr_i] && !wr_hit[bus.sb_set_addr_i];
  assign bus.pend_cnt_o    = pend_cnt;
endmodule
